// File: rtl/size_handler_pkg.sv
// Shared constants for the store-size merge unit.
// Store-size select encodings and the default data width.
package size_handler_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [2:0] SEL_SB = 3'b000;
    localparam logic [2:0] SEL_SW = 3'b001;
    localparam logic [2:0] SEL_SH = 3'b010;

endpackage

// File: rtl/size_handler_merge.sv
// Combinational byte/halfword/word merge of store data into a memory word.
// Flags any select code that is not SB, SH or SW as illegal.
module size_handler_merge
    import size_handler_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] mem,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] merged,
    output logic              illegal
);

    always_comb begin
        merged  = B;
        illegal = 1'b0;
        unique case (1'b1)
            (sel == SEL_SB): merged = {mem[DATA_W-1:8], B[7:0]};
            (sel == SEL_SH): merged = {mem[DATA_W-1:16], B[15:0]};
            (sel == SEL_SW): merged = B;
            default:         illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/size_handler_mux.sv
// Registered store-size merge stage with valid tracking.
// Define SIZE_HANDLER_ERR_EN to add the registered illegal-select err output.
module size_handler_mux
    import size_handler_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] mem,
    input  logic [DATA_W-1:0] B,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
`ifdef SIZE_HANDLER_ERR_EN
    ,
    output logic              err
`endif
);

    logic [DATA_W-1:0] merged;
    logic              illegal;

    size_handler_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .sel     (sel),
        .mem     (mem),
        .B       (B),
        .merged  (merged),
        .illegal (illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
`ifdef SIZE_HANDLER_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
`ifdef SIZE_HANDLER_ERR_EN
                // Illegal codes keep the previous word and only raise err
                err <= illegal;
                if (!illegal) begin
                    out <= merged;
                end
`else
                out <= illegal ? B : merged;
`endif
            end
        end
    end

endmodule

// File: tb/tb_size_handler_mux.sv
// Table-driven self-checking bench for size_handler_mux.
// Expected values are hand-computed; err checks apply with SIZE_HANDLER_ERR_EN.
module tb_size_handler_mux;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  sel;
        logic [31:0] mem;
        logic [31:0] b;
        logic [31:0] eout;
        logic        evld;
        logic        eerr;
    } vec_t;

`ifdef SIZE_HANDLER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  sel;
    logic [31:0] mem;
    logic [31:0] B;
    logic        in_valid;
    logic [31:0] out;
    logic        out_valid;
    logic        err_s;

    int n_checks;
    int n_fail;

    vec_t vecs[$];

    size_handler_mux #(
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .mem       (mem),
        .B         (B),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
`ifdef SIZE_HANDLER_ERR_EN
        ,
        .err       (err_s)
`endif
    );

`ifndef SIZE_HANDLER_ERR_EN
    assign err_s = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic vld, input logic [2:0] s,
                       input logic [31:0] m, input logic [31:0] b,
                       input logic [31:0] eo, input logic ev, input logic ee);
        vec_t v;
        v.rst = rst; v.vld = vld; v.sel = s; v.mem = m; v.b = b;
        v.eout = eo; v.evld = ev; v.eerr = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [2:0] s,
                         input logic [31:0] m, input logic [31:0] b);
        @(negedge clk);
        reset = rst; in_valid = vld; sel = s; mem = m; B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] eo,
                             input logic ev, input logic ee);
        chk({tag, " out"}, out, eo);
        chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, ev});
        if (ERR_EN) chk({tag, " err"}, {31'b0, err_s}, {31'b0, ee});
    endtask

    initial begin
        logic [31:0] ill_out;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; in_valid = 1'b0; sel = 3'b000; mem = '0; B = '0;

        ill_out = ERR_EN ? 32'h1122_3344 : 32'h1234_5678;

        add(1, 1, 3'b001, 32'h0, 32'hFFFF_FFFF, 32'h0, 0, 0);
        add(0, 1, 3'b000, 32'h0, 32'hFFFF_FFFF, 32'h0000_00FF, 1, 0);
        add(0, 1, 3'b001, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        add(0, 1, 3'b010, 32'h0, 32'hFFFF_FFFF, 32'h0000_FFFF, 1, 0);
        add(0, 1, 3'b000, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC44, 1, 0);
        add(0, 1, 3'b010, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_3344, 1, 0);
        add(0, 1, 3'b001, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 1, 0);
        add(0, 0, 3'b000, 32'h0, 32'hDEAD_BEEF, 32'h1122_3344, 0, 0);
        add(0, 0, 3'b010, 32'h1234_5678, 32'h0, 32'h1122_3344, 0, 0);
        add(0, 1, 3'b111, 32'h0, 32'h1234_5678, ill_out, 1, ERR_EN);
        add(0, 0, 3'b000, 32'h0, 32'h0, ill_out, 0, ERR_EN);
        add(0, 1, 3'b000, 32'hAABB_CCDD, 32'h0, 32'hAABB_CC00, 1, 0);
        add(0, 1, 3'b011, 32'hFFFF_0000, 32'h0BAD_F00D,
            ERR_EN ? 32'hAABB_CC00 : 32'h0BAD_F00D, 1, ERR_EN);
        add(1, 1, 3'b001, 32'h0, 32'h0000_0055, 32'h0, 0, 0);
        add(0, 0, 3'b001, 32'h0, 32'h0000_0055, 32'h0, 0, 0);
        add(0, 1, 3'b001, 32'h1111_1111, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].mem, vecs[i].b);
            check_all($sformatf("v%0d", i), vecs[i].eout, vecs[i].evld,
                      vecs[i].eerr);
        end

        // Reset mid-stream, then a single-cycle valid pulse after release
        drive(0, 1, 3'b000, 32'h5555_5555, 32'h0000_00AA);
        check_all("s0", 32'h5555_55AA, 1, 0);
        drive(1, 1, 3'b001, 32'h0, 32'h7777_7777);
        check_all("s1", 32'h0, 0, 0);
        drive(0, 0, 3'b001, 32'h0, 32'h7777_7777);
        check_all("s2", 32'h0, 0, 0);
        drive(0, 1, 3'b010, 32'h9999_8888, 32'hFFFF_1234);
        check_all("s3", 32'h9999_1234, 1, 0);
        drive(0, 0, 3'b001, 32'h0, 32'h0);
        check_all("s4", 32'h9999_1234, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
